frame_loader: RTL and testbench

- Write-side counterpart of the VGA display path.
- Receives a byte stream from the UART receiver, packs byte pairs into 12-bit RGB444 pixels, and writes them sequentially into the W×H frame RAM.
- Signals frame completion so the system FSM can advance to the display state (8'h03).
- Active only while the system state equals LOAD_STATE.

---
 rtl/frame_loader.sv | 126 ++++++++++++
 tb/tb_frame_loader.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/frame_loader.sv
// frame_loader
//   Write side of the frame buffer. Packs pairs of bytes from the UART
//   receiver into RGB444 pixels and writes them in row-major order into the
//   W x H frame RAM. It runs only while the system state is LOAD_STATE.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE    | not loading; pixel counter held at 0
//   WAIT_HI | waiting for the high byte (R nibble in bits [3:0])
//   WAIT_LO | high byte latched; waiting for the low byte {G,B}, timeout armed
//   DONE    | last pixel written; bytes ignored until state leaves LOAD_STATE
//
// Ports
//   clk, rst          system clock, asynchronous active-high reset
//   state             current system state code
//   rx_data, rx_valid received byte and its one-cycle strobe
//   ram_we            one-cycle write pulse per pixel, 1 clk after the low byte
//   ram_addr          pixel index of the write (held between writes)
//   ram_wdata         pixel {R,G,B} (held between writes)
//   busy              high in WAIT_HI / WAIT_LO
//   load_done         one-cycle pulse, the cycle after the write of the last pixel
module frame_loader #(
   parameter int          W          = 200,
   parameter int          H          = 150,
   parameter int          ADDR_W     = 15,
   parameter logic [7:0]  LOAD_STATE = 8'h02,
   parameter int          TIMEOUT    = 50000
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [7:0]        state,
   input  logic [7:0]        rx_data,
   input  logic              rx_valid,
   output logic              ram_we,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [11:0]       ram_wdata,
   output logic              busy,
   output logic              load_done
);

   localparam logic [ADDR_W-1:0] LAST_PIX = ADDR_W'(W * H - 1);
   localparam int                TMO_W    = $clog2(TIMEOUT + 1);
   localparam logic [TMO_W-1:0]  TMO_LOAD = TMO_W'(TIMEOUT - 1);

   typedef enum logic [1:0] {IDLE, WAIT_HI, WAIT_LO, DONE} fsm_t;

   fsm_t              cur_st, nxt_st;
   logic              active;
   logic              pix_write;
   logic [3:0]        hi_q;
   logic [ADDR_W-1:0] pix_q;
   logic [TMO_W-1:0]  tmo_q;

   assign active = (state == LOAD_STATE);
   assign busy   = (cur_st == WAIT_HI) || (cur_st == WAIT_LO);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) cur_st <= IDLE;
      else     cur_st <= nxt_st;
   end

   // Leaving LOAD_STATE takes priority over a byte arriving in the same cycle.
   always_comb begin
      nxt_st    = cur_st;
      pix_write = 1'b0;
      case (cur_st)
         IDLE:    if (active) nxt_st = WAIT_HI;
         WAIT_HI: begin
            if (!active)       nxt_st = IDLE;
            else if (rx_valid) nxt_st = WAIT_LO;
         end
         WAIT_LO: begin
            if (!active) nxt_st = IDLE;
            else if (rx_valid) begin
               pix_write = 1'b1;
               nxt_st    = (pix_q == LAST_PIX) ? DONE : WAIT_HI;
            end
            else if (tmo_q == '0) nxt_st = WAIT_HI;
         end
         DONE:    if (!active) nxt_st = IDLE;
         default: nxt_st = IDLE;
      endcase
   end

   // Timeout is a down-counter loaded while waiting for the high byte; a byte
   // arriving in the terminal-count cycle still completes the pixel.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tmo_q <= '0;
         hi_q  <= '0;
         pix_q <= '0;
      end
      else begin
         if (cur_st == WAIT_HI)
            tmo_q <= TMO_LOAD;
         else if (cur_st == WAIT_LO && !rx_valid && tmo_q != '0)
            tmo_q <= tmo_q - 1'b1;

         if (cur_st == WAIT_HI && active && rx_valid)
            hi_q <= rx_data[3:0];

         if (cur_st == IDLE)
            pix_q <= '0;
         else if (pix_write && pix_q != LAST_PIX)
            pix_q <= pix_q + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ram_we    <= 1'b0;
         ram_addr  <= '0;
         ram_wdata <= '0;
         load_done <= 1'b0;
      end
      else begin
         ram_we    <= pix_write;
         load_done <= ram_we && (ram_addr == LAST_PIX);
         if (pix_write) begin
            ram_addr  <= pix_q;
            ram_wdata <= {hi_q, rx_data};
         end
      end
   end

endmodule

// File: tb/tb_frame_loader.sv
// Directed bench for frame_loader with a 4x2 frame and a 10-cycle timeout.
module tb_frame_loader;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] state;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       ram_we;
   logic [2:0] ram_addr;
   logic [11:0] ram_wdata;
   logic       busy;
   logic       load_done;

   int total = 0;
   int bad   = 0;

   int nwr  = 0;
   int ndone = 0;
   int ndbl = 0;
   logic prev_we = 1'b0;

   logic [7:0]  fr_hi [8];
   logic [7:0]  fr_lo [8];
   logic [11:0] fr_px [8];

   frame_loader #(
      .W(4), .H(2), .ADDR_W(3), .LOAD_STATE(8'h02), .TIMEOUT(10)
   ) dut (
      .clk(clk), .rst(rst), .state(state),
      .rx_data(rx_data), .rx_valid(rx_valid),
      .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
      .busy(busy), .load_done(load_done)
   );

   always #5 clk = ~clk;

   // Counts pulses seen during the previous cycle; flags back-to-back writes.
   always @(posedge clk) begin
      if (ram_we) nwr++;
      if (load_done) ndone++;
      if (ram_we && prev_we) ndbl++;
      prev_we <= ram_we;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Called at a negedge; returns at the following negedge with the byte taken.
   task automatic strobe(input logic [7:0] b);
      rx_data  = b;
      rx_valid = 1'b1;
      @(negedge clk);
   endtask

   task automatic pixel(input logic [7:0] hi, input logic [7:0] lo, input int gap,
                        input int addr, input logic [11:0] px);
      strobe(hi);
      chk("we_after_hi", 32'(ram_we), 32'd0);
      if (gap > 0) begin
         rx_valid = 1'b0;
         repeat (gap) @(negedge clk);
      end
      strobe(lo);
      chk("we", 32'(ram_we), 32'd1);
      chk("addr", 32'(ram_addr), 32'(addr));
      chk("wdata", 32'(ram_wdata), 32'(px));
   endtask

   initial begin
      int nw0, nd0;
      fr_hi = '{8'h0A, 8'hF1, 8'h32, 8'h83, 8'h04, 8'hC5, 8'h76, 8'h07};
      fr_lo = '{8'h5C, 8'h23, 8'hFF, 8'h00, 8'h9A, 8'hBC, 8'hDE, 8'hF0};
      fr_px = '{12'hA5C, 12'h123, 12'h2FF, 12'h300, 12'h49A, 12'h5BC, 12'h6DE, 12'h7F0};

      rst = 1'b1; state = 8'h00; rx_data = 8'h00; rx_valid = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_outputs", {27'd0, ram_we, busy, load_done, ram_addr != 3'd0, ram_wdata != 12'd0}, 32'd0);
      rst = 1'b0;
      state = 8'h02;
      @(negedge clk);
      chk("busy_wait_hi", 32'(busy), 32'd1);

      // full frame: first pixel, one idle cycle, then strobes every cycle
      pixel(fr_hi[0], fr_lo[0], 0, 0, fr_px[0]);
      chk("busy_mid", 32'(busy), 32'd1);
      rx_valid = 1'b0;
      @(negedge clk);
      chk("we_hold", 32'(ram_we), 32'd0);
      chk("addr_hold", 32'(ram_addr), 32'd0);
      chk("wdata_hold", 32'(ram_wdata), 32'hA5C);
      for (int i = 1; i < 8; i++) pixel(fr_hi[i], fr_lo[i], 0, i, fr_px[i]);
      chk("done_early", 32'(load_done), 32'd0);
      chk("busy_done", 32'(busy), 32'd0);
      rx_valid = 1'b0;
      @(negedge clk);
      chk("load_done", 32'(load_done), 32'd1);
      nw0 = nwr;
      strobe(8'h11);
      strobe(8'h22);
      rx_valid = 1'b0;
      repeat (2) @(negedge clk);
      chk("load_done_once", 32'(ndone), 32'd1);
      chk("no_write_after_done", 32'(nwr - nw0), 32'd0);
      chk("frame_writes", 32'(nwr), 32'd8);

      // timeout handling on a fresh frame
      state = 8'h03;
      repeat (2) @(negedge clk);
      chk("busy_idle", 32'(busy), 32'd0);
      state = 8'h02;
      @(negedge clk);
      strobe(8'h03);
      rx_valid = 1'b0;
      repeat (12) @(negedge clk);
      pixel(8'h0F, 8'hFF, 0, 0, 12'hFFF);
      pixel(8'h01, 8'h23, 8, 1, 12'h123);
      pixel(8'h04, 8'h56, 9, 2, 12'h456);
      strobe(8'h07);
      rx_valid = 1'b0;
      repeat (10) @(negedge clk);
      pixel(8'h0E, 8'hDC, 0, 3, 12'hEDC);
      rx_valid = 1'b0;

      // abort mid-pixel, coinciding with the low byte
      state = 8'h03;
      repeat (2) @(negedge clk);
      state = 8'h02;
      @(negedge clk);
      pixel(8'h01, 8'h11, 0, 0, 12'h111);
      pixel(8'h02, 8'h22, 0, 1, 12'h222);
      pixel(8'h03, 8'h33, 0, 2, 12'h333);
      strobe(8'h04);
      nw0 = nwr;
      nd0 = ndone;
      state = 8'h03;
      strobe(8'h44);
      chk("abort_we", 32'(ram_we), 32'd0);
      chk("abort_busy", 32'(busy), 32'd0);
      rx_valid = 1'b0;
      repeat (2) @(negedge clk);
      chk("abort_no_write", 32'(nwr - nw0), 32'd0);
      chk("abort_no_done", 32'(ndone - nd0), 32'd0);
      state = 8'h02;
      @(negedge clk);
      pixel(8'h0B, 8'hCD, 0, 0, 12'hBCD);

      // asynchronous reset mid-pixel, off the clock edge
      pixel(8'h0C, 8'h99, 0, 1, 12'hC99);
      strobe(8'h05);
      rx_valid = 1'b0;
      #3 rst = 1'b1;
      #1;
      chk("arst_busy", 32'(busy), 32'd0);
      chk("arst_addr", 32'(ram_addr), 32'd0);
      chk("arst_wdata", 32'(ram_wdata), 32'd0);
      chk("arst_we_done", {30'd0, ram_we, load_done}, 32'd0);
      #3 rst = 1'b0;
      @(negedge clk);
      chk("arst_idle", 32'(busy), 32'd0);
      @(negedge clk);
      pixel(8'h0D, 8'hEF, 0, 0, 12'hDEF);
      rx_valid = 1'b0;
      repeat (2) @(negedge clk);

      chk("no_back_to_back_we", 32'(ndbl), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
